// File: rtl/ld_pkg.sv
// Shared types and constants for the left-to-right double-and-add scalar multiplier.
package ld_pkg;

  typedef struct packed {
    logic [3:0] z;
    logic [3:0] y;
    logic [3:0] x;
  } ld_point_t;

  localparam logic [1:0]  LD_OP_ADD = 2'b00;
  localparam logic [1:0]  LD_OP_DBL = 2'b01;
  localparam logic [11:0] LD_INF    = 12'h010;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_SCAN = 3'd1,
    LD_DBL  = 3'd2,
    LD_ADD  = 3'd3,
    LD_FIN  = 3'd4
  } ld_state_t;

  function automatic logic ld_is_busy(input ld_state_t st);
    return (st == LD_SCAN) || (st == LD_DBL) || (st == LD_ADD);
  endfunction

endpackage

// File: rtl/ld_scalar_mult.sv
// Scalar multiplier Q = k*P sequencing an external point ALU (double-and-add, MSB first).
// Define LD_SCALAR_CONST_TIME_EN for the fixed-latency DBL/ADD-per-bit schedule.
module ld_scalar_mult
  import ld_pkg::*;
#(
  parameter int K_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [K_W-1:0] k,
  input  logic [11:0]    p,
  output logic           busy,
  output logic           done,
  output logic [11:0]    q,
  output logic [1:0]     alu_op,
  output logic [11:0]    alu_a,
  output logic [11:0]    alu_b,
  input  logic [11:0]    alu_r
);

  localparam int I_W = (K_W > 1) ? $clog2(K_W) : 1;
  localparam logic [I_W-1:0] I_TOP  = I_W'(K_W - 1);
  localparam logic [I_W-1:0] I_ONE  = I_W'(1);
  localparam logic [I_W-1:0] I_ZERO = I_W'(0);

  ld_state_t      state_r, state_nxt_s;
  logic [I_W-1:0] i_r, i_nxt_s;
  logic [K_W-1:0] k_reg_r, k_reg_nxt_s;
  ld_point_t      p_reg_r, p_reg_nxt_s;
  ld_point_t      q_acc_r, q_acc_nxt_s;
  logic           bit_s, last_s;

  logic           busy_nxt_s, done_nxt_s;
  logic [11:0]    q_nxt_s, alu_a_nxt_s, alu_b_nxt_s;
  logic [1:0]     alu_op_nxt_s;

`ifdef LD_SCALAR_CONST_TIME_EN
  logic           started_r, started_nxt_s;
  ld_point_t      dummy_r, dummy_nxt_s;
`endif

  assign bit_s  = k_reg_r[i_r];
  assign last_s = (i_r == I_ZERO);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt_s = state_r;
    i_nxt_s     = i_r;
    k_reg_nxt_s = k_reg_r;
    p_reg_nxt_s = p_reg_r;
    q_acc_nxt_s = q_acc_r;
`ifdef LD_SCALAR_CONST_TIME_EN
    started_nxt_s = started_r;
    dummy_nxt_s   = dummy_r;
    case (state_r)
      LD_IDLE: begin
        if (start) begin
          k_reg_nxt_s   = k;
          p_reg_nxt_s   = p;
          i_nxt_s       = I_TOP;
          q_acc_nxt_s   = LD_INF;
          started_nxt_s = 1'b0;
          state_nxt_s   = LD_DBL;
        end else begin
          state_nxt_s = LD_IDLE;
        end
      end
      LD_DBL: begin
        if (started_r) begin
          q_acc_nxt_s = alu_r;
        end else begin
          dummy_nxt_s = alu_r;
        end
        state_nxt_s = LD_ADD;
      end
      LD_ADD: begin
        // The first set bit seeds the accumulator; the ALU result of that slot is thrown away.
        if (bit_s && started_r) begin
          q_acc_nxt_s = alu_r;
        end else if (bit_s) begin
          q_acc_nxt_s   = p_reg_r;
          started_nxt_s = 1'b1;
          dummy_nxt_s   = alu_r;
        end else begin
          dummy_nxt_s = alu_r;
        end
        if (last_s) begin
          state_nxt_s = LD_FIN;
        end else begin
          i_nxt_s     = i_r - I_ONE;
          state_nxt_s = LD_DBL;
        end
      end
      LD_FIN:  state_nxt_s = LD_IDLE;
      default: state_nxt_s = LD_IDLE;
    endcase
`else
    case (state_r)
      LD_IDLE: begin
        if (start) begin
          k_reg_nxt_s = k;
          p_reg_nxt_s = p;
          i_nxt_s     = I_TOP;
          state_nxt_s = LD_SCAN;
        end else begin
          state_nxt_s = LD_IDLE;
        end
      end
      LD_SCAN: begin
        if (bit_s) begin
          q_acc_nxt_s = p_reg_r;
          if (last_s) begin
            state_nxt_s = LD_FIN;
          end else begin
            i_nxt_s     = i_r - I_ONE;
            state_nxt_s = LD_DBL;
          end
        end else if (last_s) begin
          q_acc_nxt_s = LD_INF;
          state_nxt_s = LD_FIN;
        end else begin
          i_nxt_s = i_r - I_ONE;
        end
      end
      LD_DBL: begin
        q_acc_nxt_s = alu_r;
        if (bit_s) begin
          state_nxt_s = LD_ADD;
        end else if (last_s) begin
          state_nxt_s = LD_FIN;
        end else begin
          i_nxt_s = i_r - I_ONE;
        end
      end
      LD_ADD: begin
        q_acc_nxt_s = alu_r;
        if (last_s) begin
          state_nxt_s = LD_FIN;
        end else begin
          i_nxt_s     = i_r - I_ONE;
          state_nxt_s = LD_DBL;
        end
      end
      LD_FIN:  state_nxt_s = LD_IDLE;
      default: state_nxt_s = LD_IDLE;
    endcase
`endif
  end

  // Output next values, decoded from the upcoming state so every output is a flop
  always_comb begin
    busy_nxt_s   = ld_is_busy(state_nxt_s);
    done_nxt_s   = (state_nxt_s == LD_FIN);
    q_nxt_s      = q;
    alu_op_nxt_s = LD_OP_ADD;
    alu_a_nxt_s  = 12'h000;
    alu_b_nxt_s  = 12'h000;
    case (state_nxt_s)
      LD_DBL: begin
        alu_op_nxt_s = LD_OP_DBL;
        alu_a_nxt_s  = q_acc_nxt_s;
      end
      LD_ADD: begin
        alu_op_nxt_s = LD_OP_ADD;
        alu_a_nxt_s  = q_acc_nxt_s;
        alu_b_nxt_s  = p_reg_nxt_s;
      end
      LD_FIN:  q_nxt_s = q_acc_nxt_s;
      default: q_nxt_s = q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      i_r     <= I_ZERO;
      k_reg_r <= {K_W{1'b0}};
      p_reg_r <= 12'h000;
      q_acc_r <= 12'h000;
`ifdef LD_SCALAR_CONST_TIME_EN
      started_r <= 1'b0;
      dummy_r   <= 12'h000;
`endif
    end else begin
      i_r     <= i_nxt_s;
      k_reg_r <= k_reg_nxt_s;
      p_reg_r <= p_reg_nxt_s;
      q_acc_r <= q_acc_nxt_s;
`ifdef LD_SCALAR_CONST_TIME_EN
      started_r <= started_nxt_s;
      dummy_r   <= dummy_nxt_s;
`endif
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      q      <= 12'h000;
      alu_op <= LD_OP_ADD;
      alu_a  <= 12'h000;
      alu_b  <= 12'h000;
    end else begin
      busy   <= busy_nxt_s;
      done   <= done_nxt_s;
      q      <= q_nxt_s;
      alu_op <= alu_op_nxt_s;
      alu_a  <= alu_a_nxt_s;
      alu_b  <= alu_b_nxt_s;
    end
  end

endmodule

// File: tb/tb_ld_scalar_mult.sv
// Scoreboard bench for ld_scalar_mult with a nibble-wise ALU stub (add = A+B, double = 2A).
module tb_ld_scalar_mult;
  import ld_pkg::*;

  localparam int K_W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [K_W-1:0] k;
  logic [11:0]    p;
  logic           busy, done;
  logic [11:0]    q, alu_a, alu_b, alu_r;
  logic [1:0]     alu_op;

  typedef struct {
    logic [11:0] q;
    int          lat;
    string       ops;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    checks = 0;
  int    failures = 0;
  int    dones = 0;
  int    lat = 0;
  logic  busy_q = 1'b0;
  string log_s = "";

  ld_scalar_mult #(.K_W(K_W)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .p(p),
    .busy(busy), .done(done), .q(q),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_r = 12'h000;
    for (int n = 0; n < 3; n++) begin
      if (alu_op == LD_OP_ADD) begin
        alu_r[n*4 +: 4] = alu_a[n*4 +: 4] + alu_b[n*4 +: 4];
      end else begin
        alu_r[n*4 +: 4] = {alu_a[n*4 +: 3], 1'b0};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: tracks latency and ALU op log, compares against the scoreboard on done
  always @(negedge clk) begin
    if (busy && !busy_q) begin
      lat   = 1;
      log_s = "";
    end else if (lat > 0) begin
      lat++;
    end
    if (busy && alu_op == LD_OP_DBL) log_s = {log_s, "D"};
    else if (busy && alu_b != 12'h000) log_s = {log_s, "A"};
    if (done) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual q=%0h required no done", q);
      end else begin
        mon_e = sb.pop_front();
        chk("q", {20'h0, q}, {20'h0, mon_e.q});
        chk("latency", lat, mon_e.lat);
        checks++;
        if (log_s != mon_e.ops) begin
          failures++;
          $display("FAIL ops: actual=%s required=%s", log_s, mon_e.ops);
        end
      end
      lat = 0;
    end
    busy_q = busy;
  end

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: actual pending=%0d required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic run_txn(input logic [K_W-1:0] kv, input logic [11:0] pv, input logic [11:0] eq,
                         input int elat, input string eops, input int hold);
    exp_t e;
    e.q = eq; e.lat = elat; e.ops = eops;
    @(posedge clk); #1;
    start = 1'b1; k = kv; p = pv;
    sb.push_back(e);
    @(posedge clk); #1;
    if (hold > 0) begin
      k = 4'b0000; p = 12'hFFF;
      repeat (hold) @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; k = 4'b0000; p = 12'h000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_q", {20'h0, q}, 32'h0);
    chk("rst_alu_op", {30'h0, alu_op}, 32'h0);
    chk("rst_alu_a", {20'h0, alu_a}, 32'h0);
    chk("rst_alu_b", {20'h0, alu_b}, 32'h0);

`ifdef LD_SCALAR_CONST_TIME_EN
    run_txn(4'b1011, 12'h111, 12'hBBB, 9, "DADADADA", 0);
`else
    run_txn(4'b0000, 12'h123, 12'h010, 5, "", 0);
    run_txn(4'b0001, 12'h123, 12'h123, 5, "", 0);
    run_txn(4'b1011, 12'h111, 12'hBBB, 7, "DDADA", 0);
    run_txn(4'b1000, 12'h111, 12'h888, 5, "DDD", 0);

    d0 = dones;
    run_txn(4'b1011, 12'h222, 12'h666, 7, "DDADA", 3);
    chk("held_start_single_done", dones - d0, 1);

    @(posedge clk); #1;
    start = 1'b1; k = 4'b1000; p = 12'h111;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_dbl", {30'h0, alu_op}, {30'h0, LD_OP_DBL});
    chk("abort_busy_before", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_q", {20'h0, q}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    d0 = dones;
    repeat (8) @(posedge clk);
    chk("abort_no_done", dones - d0, 0);

    run_txn(4'b0110, 12'h123, 12'h6C2, 6, "DAD", 0);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
